// File: rtl/pc_flow_ctrl.sv
// Program-counter / flow-control sequencer: picks sequential, jump or conditional
// branch targets, freezes on memory stalls and flags committed redirects.
module pc_flow_ctrl #(
    parameter int                  PC_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
    parameter logic [7:0]          OP_J     = 8'h06,
    parameter logic [7:0]          OP_BEQ   = 8'h07,
    parameter logic [7:0]          OP_BNE   = 8'h0D
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                BUSYWAIT,
    input  logic [7:0]          OPCODE,
    input  logic [7:0]          OFFSET,
    input  logic                ZERO,
    output logic [PC_WIDTH-1:0] PC,
    output logic [PC_WIDTH-1:0] PC_PLUS4,
    output logic                BRANCH_TAKEN,
    output logic                FETCH_VALID
);

    typedef enum logic [1:0] {
        S_BOOT,
        S_RUN,
        S_STALL
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [PC_WIDTH-1:0] r_pc, w_pc_nxt;
    logic                r_bt, w_bt_nxt;
    logic                r_fv, w_fv_nxt;

    logic [PC_WIDTH-1:0] w_pc_plus4;
    logic [PC_WIDTH-1:0] w_off_ext;
    logic [PC_WIDTH-1:0] w_target;
    logic                w_take;

    // Word offset: sign-extend the 8-bit field and scale by 4 (needs PC_WIDTH >= 10).
    assign w_pc_plus4 = r_pc + PC_WIDTH'(4);
    assign w_off_ext  = {{(PC_WIDTH-10){OFFSET[7]}}, OFFSET, 2'b00};
    assign w_target   = w_pc_plus4 + w_off_ext;
    assign w_take     = (OPCODE == OP_J)
                      | ((OPCODE == OP_BEQ) &  ZERO)
                      | ((OPCODE == OP_BNE) & ~ZERO);

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_bt_nxt    = 1'b0;
        w_fv_nxt    = r_fv;
        case (r_state)
            S_BOOT: begin
                w_state_nxt = S_RUN;
                w_fv_nxt    = 1'b1;
            end
            S_RUN, S_STALL: begin
                // A stalled branch is re-evaluated with whatever ZERO holds at release.
                if (BUSYWAIT) begin
                    w_state_nxt = S_STALL;
                end else begin
                    w_state_nxt = S_RUN;
                    w_pc_nxt    = w_take ? w_target : w_pc_plus4;
                    w_bt_nxt    = w_take;
                end
            end
            default: begin
                w_state_nxt = S_BOOT;
                w_fv_nxt    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= S_BOOT;
            r_pc    <= RESET_PC;
            r_bt    <= 1'b0;
            r_fv    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_bt    <= w_bt_nxt;
            r_fv    <= w_fv_nxt;
        end
    end

    assign PC           = r_pc;
    assign PC_PLUS4     = w_pc_plus4;
    assign BRANCH_TAKEN = r_bt;
    assign FETCH_VALID  = r_fv;

endmodule
